// File: rtl/input_debouncer_pkg.sv
// Shared types and parameter limits for the input debouncer and its synchroniser.
package input_debouncer_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'b00,
        PEND_HI   = 2'b01,
        STABLE_HI = 2'b10,
        PEND_LO   = 2'b11
    } db_state_t;

    localparam int MIN_SYNC_STAGES     = 2;
    localparam int MIN_DEBOUNCE_CYCLES = 2;

endpackage

// File: rtl/input_debouncer_sync_chain.sv
// Synchronous-reset flop chain that brings an asynchronous level into the clk domain.
module sync_chain #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] stages;

    always_ff @(posedge clk) begin
        if (reset) begin
            stages <= '0;
        end else begin
            stages <= {stages[SYNC_STAGES-2:0], d};
        end
    end

    assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// Debounces a synchronised raw input: clean level, edge pulses and a saturating glitch count.
module input_debouncer
    import input_debouncer_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int GLITCH_W        = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                raw_in,
    input  logic                clr_glitch,
    output logic                in_clean,
    output logic                rise_pulse,
    output logic                fall_pulse,
    output logic [1:0]          db_state,
    output logic [GLITCH_W-1:0] glitch_cnt
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]    CNT_ONE    = CNT_W'(1);
    localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;

    if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_sync
        $error("input_debouncer: SYNC_STAGES below minimum");
    end
    if (DEBOUNCE_CYCLES < MIN_DEBOUNCE_CYCLES) begin : g_bad_db
        $error("input_debouncer: DEBOUNCE_CYCLES below minimum");
    end

    logic             s;
    db_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_clean_d, rise_d, fall_d, glitch_evt;

    sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (raw_in),
        .q     (s)
    );

    // cnt holds how many consecutive samples have disagreed with the accepted level.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        in_clean_d = in_clean;
        rise_d     = 1'b0;
        fall_d     = 1'b0;
        glitch_evt = 1'b0;
        case (state_q)
            STABLE_LO: begin
                if (s) begin
                    state_d = PEND_HI;
                    cnt_d   = CNT_ONE;
                end
            end
            PEND_HI: begin
                if (!s) begin
                    state_d    = STABLE_LO;
                    cnt_d      = '0;
                    glitch_evt = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d    = STABLE_HI;
                    in_clean_d = 1'b1;
                    rise_d     = 1'b1;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STABLE_HI: begin
                if (!s) begin
                    state_d = PEND_LO;
                    cnt_d   = CNT_ONE;
                end
            end
            PEND_LO: begin
                if (s) begin
                    state_d    = STABLE_HI;
                    cnt_d      = '0;
                    glitch_evt = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d    = STABLE_LO;
                    in_clean_d = 1'b0;
                    fall_d     = 1'b1;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = STABLE_LO;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= STABLE_LO;
            cnt_q      <= '0;
            in_clean   <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            glitch_cnt <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            in_clean   <= in_clean_d;
            rise_pulse <= rise_d;
            fall_pulse <= fall_d;
            // Clear takes precedence over a coincident glitch; the count never wraps.
            if (clr_glitch) begin
                glitch_cnt <= '0;
            end else if (glitch_evt && glitch_cnt != GLITCH_MAX) begin
                glitch_cnt <= glitch_cnt + GLITCH_W'(1);
            end
        end
    end

    assign db_state = state_q;

endmodule

// File: tb/tb_input_debouncer.sv
// Self-checking bench for input_debouncer: directed scenarios plus random stimulus vs. a run-length model.
module tb_input_debouncer;

    localparam int SYNC   = 2;
    localparam int DB     = 4;
    localparam int GW     = 8;
    localparam int GMAX   = (1 << GW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          raw_in;
    logic          clr_glitch;
    logic          in_clean;
    logic          rise_pulse;
    logic          fall_pulse;
    logic [1:0]    db_state;
    logic [GW-1:0] glitch_cnt;

    int checks   = 0;
    int failures = 0;

    input_debouncer #(
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DB),
        .GLITCH_W        (GW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .raw_in     (raw_in),
        .clr_glitch (clr_glitch),
        .in_clean   (in_clean),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .db_state   (db_state),
        .glitch_cnt (glitch_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: delayed samples, accepted level and length of the current disagreeing run.
    logic m_pipe [SYNC];
    logic m_clean, m_rise, m_fall;
    int   m_run, m_gcnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic c, input logic rst);
        logic s, glitch;
        if (rst) begin
            for (int i = 0; i < SYNC; i++) m_pipe[i] = 1'b0;
            m_clean = 1'b0; m_rise = 1'b0; m_fall = 1'b0;
            m_run = 0; m_gcnt = 0;
        end else begin
            s = m_pipe[SYNC-1];
            m_rise = 1'b0; m_fall = 1'b0; glitch = 1'b0;
            if (s != m_clean) begin
                m_run++;
                if (m_run == DB) begin
                    m_clean = s; m_rise = s; m_fall = !s; m_run = 0;
                end
            end else if (m_run > 0) begin
                glitch = 1'b1; m_run = 0;
            end
            if (c) m_gcnt = 0;
            else if (glitch && m_gcnt < GMAX) m_gcnt++;
            for (int i = SYNC - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
            m_pipe[0] = r;
        end
    endtask

    function automatic logic glitch_next();
        return (m_run > 0) && (m_pipe[SYNC-1] == m_clean);
    endfunction

    task automatic step(input logic r, input logic c, input logic rst);
        raw_in = r; clr_glitch = c; reset = rst;
        @(posedge clk);
        model_edge(r, c, rst);
        #1;
        chk("in_clean", 32'(in_clean), 32'(m_clean));
        chk("rise_pulse", 32'(rise_pulse), 32'(m_rise));
        chk("fall_pulse", 32'(fall_pulse), 32'(m_fall));
        chk("db_state", 32'(db_state), 32'({m_clean, m_run != 0}));
        chk("glitch_cnt", 32'(glitch_cnt), 32'(m_gcnt));
        chk("pulse_excl", 32'(rise_pulse & fall_pulse), 32'd0);
    endtask

    int   rise_edge, n_rise, n_fall, base_g, len;
    logic saw_hi, saw_lo, hit, lvl;
    logic [1:0] seq [0:10];

    initial begin
        raw_in = 1'b1; clr_glitch = 1'b0; reset = 1'b1;
        for (int i = 0; i < SYNC; i++) m_pipe[i] = 1'b0;
        m_clean = 0; m_rise = 0; m_fall = 0; m_run = 0; m_gcnt = 0;

        // Reset held with raw_in high, then release and hold high.
        repeat (3) step(1'b1, 1'b0, 1'b1);
        chk("reset_db_state", 32'(db_state), 32'd0);
        chk("reset_glitch", 32'(glitch_cnt), 32'd0);
        rise_edge = -1; n_rise = 0;
        for (int k = 1; k <= 10; k++) begin
            step(1'b1, 1'b0, 1'b0);
            seq[k] = db_state;
            if (in_clean && rise_edge < 0) rise_edge = k;
            n_rise += int'(rise_pulse);
        end
        chk("rise_latency", 32'(rise_edge), 32'd6);
        chk("rise_count", 32'(n_rise), 32'd1);
        chk("seq_e2", 32'(seq[2]), 32'd0);
        chk("seq_e3", 32'(seq[3]), 32'd1);
        chk("seq_e5", 32'(seq[5]), 32'd1);
        chk("seq_e6", 32'(seq[6]), 32'd2);

        // Back to low, then a 3-cycle pulse must be rejected.
        repeat (10) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        saw_hi = 1'b0; n_rise = 0;
        repeat (3) step(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b0, 1'b0);
            saw_hi |= in_clean;
            n_rise += int'(rise_pulse);
        end
        chk("short_clean", 32'(saw_hi), 32'd0);
        chk("short_rise", 32'(n_rise), 32'd0);
        chk("short_glitch", 32'(glitch_cnt), 32'd1);
        chk("short_state", 32'(db_state), 32'd0);

        // A 4-cycle pulse must be accepted and then released.
        step(1'b0, 1'b1, 1'b0);
        n_rise = 0; n_fall = 0;
        for (int k = 0; k < 16; k++) begin
            step(k < 4, 1'b0, 1'b0);
            n_rise += int'(rise_pulse);
            n_fall += int'(fall_pulse);
        end
        chk("exact_rise", 32'(n_rise), 32'd1);
        chk("exact_fall", 32'(n_fall), 32'd1);
        chk("exact_glitch", 32'(glitch_cnt), 32'd0);
        chk("exact_clean", 32'(in_clean), 32'd0);

        // Saturate the glitch counter.
        for (int k = 0; k < 300; k++) begin
            step(1'b1, 1'b0, 1'b0); step(1'b1, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
        end
        chk("sat_255", 32'(glitch_cnt), 32'd255);
        repeat (5) begin
            step(1'b1, 1'b0, 1'b0); step(1'b1, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
        end
        chk("sat_hold", 32'(glitch_cnt), 32'd255);

        // Clear coinciding with a glitch event.
        hit = 1'b0;
        step(1'b1, 1'b0, 1'b0); step(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 8 && !hit; k++) begin
            if (glitch_next()) begin
                hit = 1'b1;
                step(1'b0, 1'b1, 1'b0);
                chk("clr_wins", 32'(glitch_cnt), 32'd0);
            end else begin
                step(1'b0, 1'b0, 1'b0);
            end
        end
        chk("clr_hit", 32'(hit), 32'd1);

        // Reset while pending high with cnt == 2.
        repeat (4) step(1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 10 && m_run != 2; k++) step(1'b1, 1'b0, 1'b0);
        chk("mid_pend_state", 32'(db_state), 32'd1);
        step(1'b0, 1'b0, 1'b1);
        chk("mid_rst_state", 32'(db_state), 32'd0);
        chk("mid_rst_clean", 32'(in_clean), 32'd0);
        chk("mid_rst_pulse", 32'(rise_pulse | fall_pulse), 32'd0);
        chk("mid_rst_glitch", 32'(glitch_cnt), 32'd0);

        // Steady high, then a 3-cycle low dip must be rejected.
        repeat (10) step(1'b1, 1'b0, 1'b0);
        base_g = int'(glitch_cnt);
        saw_lo = 1'b0; n_fall = 0;
        repeat (3) step(1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 1'b0, 1'b0);
            saw_lo |= !in_clean;
            n_fall += int'(fall_pulse);
        end
        chk("dip_clean", 32'(saw_lo), 32'd0);
        chk("dip_fall", 32'(n_fall), 32'd0);
        chk("dip_glitch", 32'(glitch_cnt), 32'(base_g + 1));
        chk("dip_state", 32'(db_state), 32'd2);

        // Random run lengths with occasional clears and resets.
        for (int r = 0; r < 80; r++) begin
            lvl = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 7);
            for (int k = 0; k < len; k++)
                step(lvl, $urandom_range(0, 19) == 0, $urandom_range(0, 149) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
